// File: rtl/flag_context_ctrl.sv
// Flag-register update sequencer with a LIFO of saved flag contexts for nested traps.
// Optional FLAG_CTX_DEBUG_EN adds dbg_top / dbg_watermark observation ports.
module flag_context_ctrl #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [2:0]    instr_class,
  input  logic          stall,
  input  logic          trap_req,
  input  logic          ret_req,
  input  logic [4:0]    flags_in,
  output logic          spec_enable,
  output logic [2:0]    spec_update_mode,
  output logic          load_valid,
  output logic [4:0]    load_flags,
  output logic          trap_ack,
  output logic          ret_ack,
  output logic          busy,
  output logic [CW-1:0] stack_count,
`ifdef FLAG_CTX_DEBUG_EN
  output logic [4:0]    dbg_top,
  output logic [CW-1:0] dbg_watermark,
`endif
  output logic          overflow_err,
  output logic          underflow_err
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0]    MODE_TOGGLE = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_TOGGLE, S_POP, S_LOAD} state_t;

  state_t               state, state_nxt;
  logic [DEPTH-1:0][4:0] stack;
  logic                 full, empty, trap_take, ret_look, ret_take;
  logic [CW-1:0]        cnt_m1;
  logic [AW-1:0]        wr_idx, top_idx;

  assign full      = (stack_count == DEPTH_C);
  assign empty     = (stack_count == '0);
  // A refused trap is treated as absent so returns can still drain the stack.
  assign trap_take = trap_req && !full;
  assign ret_look  = ret_req && !trap_take;
  assign ret_take  = ret_look && !empty;
  assign cnt_m1    = stack_count - CW'(1);
  assign wr_idx    = stack_count[AW-1:0];
  assign top_idx   = cnt_m1[AW-1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trap_take)     state_nxt = S_PUSH;
        else if (ret_take) state_nxt = S_POP;
      end
      S_PUSH:   state_nxt = S_TOGGLE;
      S_TOGGLE: state_nxt = S_IDLE;
      S_POP:    state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Instruction path stays combinational so it lines up with same-cycle ALU flags.
  always_comb begin
    spec_update_mode = 3'd0;
    trap_ack         = 1'b0;
    ret_ack          = 1'b0;
    load_valid       = 1'b0;
    busy             = 1'b0;
    if (!reset) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (!trap_take && !ret_take && instr_valid && !stall && spec_enable &&
              instr_class <= 3'd4)
            spec_update_mode = instr_class;
        end
        S_TOGGLE: begin
          spec_update_mode = MODE_TOGGLE;
          trap_ack         = 1'b1;
        end
        S_LOAD: begin
          load_valid = 1'b1;
          ret_ack    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_enable   <= 1'b0;
      stack_count   <= '0;
      load_flags    <= 5'd0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      spec_enable <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trap_req && full)  overflow_err  <= 1'b1;
          if (ret_look && empty) underflow_err <= 1'b1;
        end
        S_PUSH: stack_count <= stack_count + CW'(1);
        S_POP: begin
          stack_count <= cnt_m1;
          load_flags  <= stack[top_idx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state == S_PUSH) stack[wr_idx] <= flags_in;
  end

`ifdef FLAG_CTX_DEBUG_EN
  assign dbg_top = empty ? 5'd0 : stack[top_idx];

  always_ff @(posedge clock) begin
    if (reset)                           dbg_watermark <= '0;
    else if (stack_count > dbg_watermark) dbg_watermark <= stack_count;
  end
`endif

endmodule

// File: tb/tb_flag_context_ctrl.sv
// Directed-vector bench for flag_context_ctrl: idle updates, trap/return, overflow/underflow, reset abort.
module tb_flag_context_ctrl;

  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset, instr_valid, stall, trap_req, ret_req;
  logic [2:0]    instr_class;
  logic [4:0]    flags_in;
  logic          spec_enable, load_valid, trap_ack, ret_ack, busy;
  logic          overflow_err, underflow_err;
  logic [2:0]    spec_update_mode;
  logic [4:0]    load_flags;
  logic [CW-1:0] stack_count;
`ifdef FLAG_CTX_DEBUG_EN
  logic [4:0]    dbg_top;
  logic [CW-1:0] dbg_watermark;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  flag_context_ctrl #(.DEPTH(4), .CW(CW)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_class(instr_class),
    .stall(stall), .trap_req(trap_req), .ret_req(ret_req), .flags_in(flags_in),
    .spec_enable(spec_enable), .spec_update_mode(spec_update_mode), .load_valid(load_valid),
    .load_flags(load_flags), .trap_ack(trap_ack), .ret_ack(ret_ack), .busy(busy),
    .stack_count(stack_count),
`ifdef FLAG_CTX_DEBUG_EN
    .dbg_top(dbg_top), .dbg_watermark(dbg_watermark),
`endif
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and let inputs/outputs settle away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_trap(input logic [4:0] f, input int cnt_after);
    flags_in = f; trap_req = 1'b1;
    tick();
    chk("trap_push_busy", busy, 1);
    chk("trap_push_ack", trap_ack, 0);
    tick();
    chk("trap_toggle_mode", spec_update_mode, 5);
    chk("trap_toggle_ack", trap_ack, 1);
    chk("trap_count", stack_count, cnt_after);
    trap_req = 1'b0;
    tick();
    chk("trap_back_idle", busy, 0);
  endtask

  task automatic do_ret(input logic [4:0] f, input int cnt_after);
    ret_req = 1'b1;
    tick();
    chk("ret_pop_busy", busy, 1);
    chk("ret_pop_ack", ret_ack, 0);
    tick();
    chk("ret_load_valid", load_valid, 1);
    chk("ret_load_flags", load_flags, f);
    chk("ret_ack", ret_ack, 1);
    chk("ret_count", stack_count, cnt_after);
    ret_req = 1'b0;
    tick();
    chk("ret_back_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_class = 3'd0; stall = 1'b0;
    trap_req = 1'b0; ret_req = 1'b0; flags_in = 5'd0;
    tick();
    chk("rst_spec_enable", spec_enable, 0);
    chk("rst_mode", spec_update_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", stack_count, 0);
    chk("rst_load_flags", load_flags, 0);
    chk("rst_errs", {overflow_err, underflow_err, load_valid, trap_ack, ret_ack}, 0);
    reset = 1'b0;
    tick();
    chk("spec_enable_up", spec_enable, 1);
    instr_valid = 1'b1; instr_class = 3'd2; settle();
    chk("idle_class2", spec_update_mode, 2);
    instr_class = 3'd4; settle();
    chk("idle_class4", spec_update_mode, 4);
    instr_class = 3'd6; settle();
    chk("idle_class6", spec_update_mode, 0);
    instr_class = 3'd2; stall = 1'b1; settle();
    chk("idle_stall", spec_update_mode, 0);
    stall = 1'b0;

    // Trap entry with an instruction update pending: trap wins, mode forced 0.
    flags_in = 5'b01100; trap_req = 1'b1; settle();
    chk("trap_prio_mode", spec_update_mode, 0);
    tick();
    chk("push_busy", busy, 1);
    chk("push_mode", spec_update_mode, 0);
    tick();
    chk("toggle_mode", spec_update_mode, 5);
    chk("toggle_ack", trap_ack, 1);
    chk("toggle_count", stack_count, 1);
    trap_req = 1'b0;
    tick();
    chk("post_trap_mode", spec_update_mode, 2);
    instr_valid = 1'b0;
    do_ret(5'b01100, 0);

    // Fill the stack, then one more trap is refused.
    for (int i = 1; i <= 4; i++) do_trap(5'(i), i);
    flags_in = 5'd5; trap_req = 1'b1;
    tick();
    chk("ovf_err", overflow_err, 1);
    chk("ovf_busy", busy, 0);
    tick();
    chk("ovf_no_ack", trap_ack, 0);
    chk("ovf_count", stack_count, 4);
    trap_req = 1'b0;
    tick();
    for (int i = 4; i >= 1; i--) do_ret(5'(i), i - 1);

    // Underflow, then stickiness across a successful trap/return.
    ret_req = 1'b1;
    tick();
    chk("unf_err", underflow_err, 1);
    chk("unf_busy", busy, 0);
    tick();
    chk("unf_no_ack", ret_ack, 0);
    ret_req = 1'b0;
    tick();
    do_trap(5'd7, 1);
    do_ret(5'd7, 0);
    chk("unf_sticky", underflow_err, 1);
    chk("ovf_sticky", overflow_err, 1);

    // Simultaneous trap+return: trap first, return after trap_ack, reset during POP.
    flags_in = 5'd9; trap_req = 1'b1; ret_req = 1'b1; instr_valid = 1'b1; instr_class = 3'd3;
    settle();
    chk("both_mode0", spec_update_mode, 0);
    tick();
    chk("both_push", busy, 1);
    tick();
    chk("both_trap_ack", trap_ack, 1);
    chk("both_no_ret_ack", ret_ack, 0);
    trap_req = 1'b0;
    tick();
    chk("both_ret_idle_busy", busy, 0);
    chk("both_ret_mode0", spec_update_mode, 0);
    tick();
    chk("both_pop_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk("abort_no_ack", ret_ack, 0);
    chk("abort_no_load", load_valid, 0);
    chk("abort_count", stack_count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_errs", {overflow_err, underflow_err}, 0);
    chk("abort_spec_enable", spec_enable, 0);
    reset = 1'b0; ret_req = 1'b0; instr_valid = 1'b0;
    tick();
    tick();
    chk("final_idle_ack", {trap_ack, ret_ack, load_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
